// File: rtl/obd_uart_reporter.sv
// obd_uart_reporter
//   Transmit side of the vehicle telemetry link. On an enabled report trigger the
//   vehicle state is snapshotted and sent as a fixed 13-byte checksummed frame on
//   a UART 8N1 line (start 0, 8 data bits LSB first, stop 1, no inter-byte gap).
//
//   Frame: A5(SYNC) | gear | speed | rpm[13:8] | rpm[7:0] | fuel | temp |
//          odo[31:24] | odo[23:16] | odo[15:8] | odo[7:0] | ess | XOR(bytes 1..11)
//
// Ports
//   clk           system clock
//   rst           asynchronous reset, active low
//   en            report enable; triggers ignored while low
//   trigger       one-cycle report request
//   current_gear  gear code (3:P 6:R 9:N 12:D)
//   speed, rpm, fuel, temp, odometer_raw, ess_trigger   vehicle state
//   uart_tx       serial line, idle high (registered)
//   busy          frame in progress, including the DONE cycle
//   frame_done    one-cycle pulse in the DONE cycle
//   drop_cnt      triggers lost while busy, saturating at 255
//
// state   | meaning
// --------+--------------------------------------------------------
// S_IDLE  | line high, waiting for trigger & en
// S_START | start bit of byte byte_q
// S_DATA  | data bit bit_q of byte byte_q
// S_STOP  | stop bit; after byte 12 go to S_DONE, else next byte
// S_DONE  | one cycle: frame_done=1, busy=1, line high
module obd_uart_reporter #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        trigger,
  input  logic [3:0]  current_gear,
  input  logic [7:0]  speed,
  input  logic [13:0] rpm,
  input  logic [7:0]  fuel,
  input  logic [7:0]  temp,
  input  logic [31:0] odometer_raw,
  input  logic        ess_trigger,
  output logic        uart_tx,
  output logic        busy,
  output logic        frame_done,
  output logic [7:0]  drop_cnt
);

  localparam int unsigned   TW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] TMR_LAST  = TW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]    LAST_BYTE = 4'd12;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [2:0]    bit_q, bit_d;
  logic [3:0]    byte_q, byte_d;
  logic          tx_d;
  logic [7:0]    tx_byte;
  logic [7:0]    checksum;
  logic          accept;
  logic          bit_end;

  logic [3:0]    snap_gear;
  logic [7:0]    snap_speed;
  logic [13:0]   snap_rpm;
  logic [7:0]    snap_fuel;
  logic [7:0]    snap_temp;
  logic [31:0]   snap_odo;
  logic          snap_ess;

  assign busy       = (state_q != S_IDLE);
  assign frame_done = (state_q == S_DONE);
  assign accept     = trigger & en & ~busy;
  assign bit_end    = (tmr_q == TMR_LAST);

  // Checksum is built from the snapshot so late input changes cannot corrupt it.
  assign checksum = {4'h0, snap_gear} ^ snap_speed ^ {2'b00, snap_rpm[13:8]} ^ snap_rpm[7:0]
                  ^ snap_fuel ^ snap_temp
                  ^ snap_odo[31:24] ^ snap_odo[23:16] ^ snap_odo[15:8] ^ snap_odo[7:0]
                  ^ {7'b0, snap_ess};

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    if (state_q == S_START || state_q == S_DATA || state_q == S_STOP) begin
      tmr_d = bit_end ? '0 : tmr_q + TW'(1);
    end
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_START;
          tmr_d   = '0;
          bit_d   = '0;
          byte_d  = '0;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          bit_d   = '0;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (bit_q == 3'd7) state_d = S_STOP;
          else               bit_d   = bit_q + 3'd1;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (byte_q == LAST_BYTE) begin
            state_d = S_DONE;
          end else begin
            state_d = S_START;
            byte_d  = byte_q + 4'd1;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Byte selected for the upcoming cycle (indexed by next-state counters so the
  // line output can be registered without a cycle of skew).
  always_comb begin
    tx_byte = 8'hFF;
    case (byte_d)
      4'd0:    tx_byte = SYNC_BYTE;
      4'd1:    tx_byte = {4'h0, snap_gear};
      4'd2:    tx_byte = snap_speed;
      4'd3:    tx_byte = {2'b00, snap_rpm[13:8]};
      4'd4:    tx_byte = snap_rpm[7:0];
      4'd5:    tx_byte = snap_fuel;
      4'd6:    tx_byte = snap_temp;
      4'd7:    tx_byte = snap_odo[31:24];
      4'd8:    tx_byte = snap_odo[23:16];
      4'd9:    tx_byte = snap_odo[15:8];
      4'd10:   tx_byte = snap_odo[7:0];
      4'd11:   tx_byte = {7'b0, snap_ess};
      4'd12:   tx_byte = checksum;
      default: tx_byte = 8'hFF;
    endcase
  end

  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = tx_byte[bit_d];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      tmr_q      <= '0;
      bit_q      <= '0;
      byte_q     <= '0;
      uart_tx    <= 1'b1;
      drop_cnt   <= '0;
      snap_gear  <= '0;
      snap_speed <= '0;
      snap_rpm   <= '0;
      snap_fuel  <= '0;
      snap_temp  <= '0;
      snap_odo   <= '0;
      snap_ess   <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      uart_tx <= tx_d;
      if (accept) begin
        snap_gear  <= current_gear;
        snap_speed <= speed;
        snap_rpm   <= rpm;
        snap_fuel  <= fuel;
        snap_temp  <= temp;
        snap_odo   <= odometer_raw;
        snap_ess   <= ess_trigger;
      end
      if (trigger && en && busy && drop_cnt != 8'hFF) begin
        drop_cnt <= drop_cnt + 8'd1;
      end
    end
  end

endmodule
